// File: rtl/fridge_compressor_scheduler_if.sv
// Signal bundle between the fridge datapath / compressor drivers and the scheduler.
// The master side owns power enable and temperatures; the slave (scheduler) owns the drive outputs.
interface fridge_compressor_scheduler_if;
    logic        i;
    logic [19:0] meas_t;
    logic [19:0] set_t;
    logic        comp_on;
    logic [3:0]  valve;
    logic [1:0]  active_id;
    logic [3:0]  demand;
    logic        busy;

    modport master (
        output i, meas_t, set_t,
        input  comp_on, valve, active_id, demand, busy
    );

    modport slave (
        input  i, meas_t, set_t,
        output comp_on, valve, active_id, demand, busy
    );
endinterface

// File: rtl/fridge_compressor_scheduler.sv
// Round-robin compressor sharing across four compartments with hysteresis demand,
// minimum on/off times and a maximum run slice per grant.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OFF     | power disabled, everything idle and cleared
// LOCKOUT | anti short-cycle wait, compressor off for MIN_OFF cycles
// IDLE    | compressor off, waiting for any compartment demand
// RUN     | compressor on, valve open to active_id
module fridge_compressor_scheduler #(
    parameter int MIN_ON  = 8,
    parameter int MIN_OFF = 4,
    parameter int MAX_RUN = 16,
    parameter int HYST    = 2
) (
    input logic                          clk,
    input logic                          rst_n,
    fridge_compressor_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_OFF, S_LOCKOUT, S_IDLE, S_RUN} state_t;

    localparam logic [5:0] HYST6      = 6'(HYST);
    localparam logic [7:0] MIN_ON_TC  = 8'(MIN_ON - 1);
    localparam logic [7:0] MIN_OFF_TC = 8'(MIN_OFF - 1);
    localparam logic [7:0] MAX_RUN_TC = 8'(MAX_RUN - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] active_q, active_d;
    logic [1:0] last_q, last_d;
    logic [3:0] demand_q, demand_d;
    logic       comp_on_q;
    logic [3:0] valve_q;
    logic       busy_q;

    logic [3:0] others;
    logic       satisfied;
    logic       min_met;
    logic       slice_done;

    // First requester scanning upward from last+1; offset 4 wraps back to last itself.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int o = 1; o <= 4; o++) begin
            idx = last + 2'(o);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        logic [5:0] m;
        logic [5:0] s;
        demand_d = demand_q;
        m        = '0;
        s        = '0;
        for (int k = 0; k < 4; k++) begin
            m = {1'b0, bus.meas_t[5*k +: 5]};
            s = {1'b0, bus.set_t[5*k +: 5]};
            if (m > s + HYST6) begin
                demand_d[k] = 1'b1;
            end else if (m <= s) begin
                demand_d[k] = 1'b0;
            end
        end
        if (!bus.i) begin
            demand_d = '0;
        end
    end

    assign others     = demand_q & ~(4'b0001 << active_q);
    assign satisfied  = !demand_q[active_q];
    assign min_met    = timer_q >= MIN_ON_TC;
    // Past the slice a late-arriving demander still gets its turn, not only at the exact count.
    assign slice_done = timer_q >= MAX_RUN_TC;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        active_d = active_q;
        last_d   = last_q;
        unique case (state_q)
            S_OFF: begin
                timer_d  = '0;
                active_d = '0;
                if (bus.i) begin
                    state_d = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == MIN_OFF_TC) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_IDLE: begin
                if (demand_q != 4'b0000) begin
                    active_d = rr_pick(demand_q, last_q);
                    last_d   = rr_pick(demand_q, last_q);
                    timer_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
                if ((satisfied && min_met) || slice_done) begin
                    if (others != 4'b0000) begin
                        active_d = rr_pick(others, active_q);
                        last_d   = rr_pick(others, active_q);
                        timer_d  = '0;
                    end else if (satisfied && min_met) begin
                        state_d = S_LOCKOUT;
                        timer_d = '0;
                    end
                end
            end
            default: state_d = S_OFF;
        endcase
        if (!bus.i) begin
            state_d  = S_OFF;
            timer_d  = '0;
            active_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            timer_q   <= '0;
            active_q  <= '0;
            last_q    <= 2'd3;
            demand_q  <= '0;
            comp_on_q <= 1'b0;
            valve_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            active_q  <= active_d;
            last_q    <= last_d;
            demand_q  <= demand_d;
            comp_on_q <= (state_d == S_RUN);
            valve_q   <= (state_d == S_RUN) ? (4'b0001 << active_d) : 4'b0000;
            busy_q    <= (state_d == S_RUN) || (state_d == S_LOCKOUT);
        end
    end

    assign bus.comp_on   = comp_on_q;
    assign bus.valve     = valve_q;
    assign bus.active_id = active_q;
    assign bus.demand    = demand_q;
    assign bus.busy      = busy_q;
endmodule
